// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, count limits and prescaler math for the stopwatch family
package stopwatch_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
   localparam int MAX_COUNT = 9999;
   localparam int W = $clog2(MAX_COUNT + 1);
   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction
endpackage

// File: rtl/countdown_timer_tick_gen.sv
// tick_gen: prescaler that emits a one-cycle tick every DIV enabled cycles, holding phase while disabled
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] r_cnt;
   assign o_tick = i_en && (r_cnt == CW'(DIV - 1));
   always_ff @(posedge clk)
      if (reset || i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loads a clamped preset, decrements once per tick while running, flags expiry at zero
module countdown_timer
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int MAX_COUNT = stopwatch_pkg::MAX_COUNT,
   parameter int W         = $clog2(MAX_COUNT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_run,
   input  logic         i_load,
   input  logic [W-1:0] i_preset,
   output logic [W-1:0] o_count,
   output logic         o_running,
   output logic         o_done,
   output logic         o_expired
);
   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   state_t       r_state, w_next;
   logic [W-1:0] r_count, w_count, w_clamped;
   logic         r_done, w_done, r_load_d, w_load_rise, w_tick;
   assign w_load_rise = i_load && !r_load_d;
   assign w_clamped   = (i_preset > W'(MAX_COUNT)) ? W'(MAX_COUNT) : i_preset;
   // prescaler restarts from zero whenever the timer leaves the running/paused pair
   tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .i_en  (r_state == RUN),
      .i_clr ((r_state == IDLE) || (r_state == PAUSE && w_load_rise)),
      .o_tick(w_tick)
   );
   always_comb begin
      w_next  = r_state;
      w_count = r_count;
      w_done  = 1'b0;
      case (r_state)
         IDLE:
            if (w_load_rise) w_count = w_clamped;
            else if (i_run && r_count != '0) w_next = RUN;
         RUN: begin
            if (w_tick) w_count = r_count - 1'b1;
            if (w_tick && r_count == W'(1)) begin
               w_done = 1'b1;
               w_next = DONE;
            end else if (!i_run) w_next = PAUSE;
         end
         PAUSE:
            if (w_load_rise) begin
               w_count = w_clamped;
               w_next  = IDLE;
            end else if (i_run) w_next = RUN;
         DONE: begin
            w_count = '0;
            if (!i_run) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_done   <= 1'b0;
         r_load_d <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_count  <= w_count;
         r_done   <= w_done;
         r_load_d <= i_load;
      end
   assign o_count   = r_count;
   assign o_running = (r_state == RUN);
   assign o_expired = (r_state == DONE);
   assign o_done    = r_done;
endmodule
